// File: rtl/uart_pkg.sv
// Shared constants for the UART receiver: FSM state encoding and oversampling points.
package uart_pkg;

  localparam int unsigned OVERSAMPLE  = 16;
  localparam int unsigned MID_SAMPLE  = 7;
  localparam int unsigned LAST_SAMPLE = 15;

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] START     = 3'd1;
  localparam logic [2:0] DATA      = 3'd2;
  localparam logic [2:0] PARITY    = 3'd3;
  localparam logic [2:0] STOP      = 3'd4;
  localparam logic [2:0] WAIT_HIGH = 3'd5;

endpackage

// File: rtl/sync_2ff.sv
// Generic 1-bit two-flop synchronizer; resets to 1 so an idle-high line reads idle.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 16x-oversampled UART receiver with ready/clear handshake, framing and overrun status.
// Define UART_RX_PARITY_EN to expect an even-parity bit and expose parity_err.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rxclk_en,
  input  logic                 rx,
  input  logic                 rdy_clr,
  output logic [DATA_BITS-1:0] data,
  output logic                 ready,
  output logic                 frame_err,
  output logic                 overrun,
`ifdef UART_RX_PARITY_EN
  output logic                 parity_err,
`endif
  output logic                 busy
);

  localparam int unsigned BW = $clog2(DATA_BITS + 1);
  localparam int unsigned SW = $clog2(OVERSAMPLE);
  localparam logic [SW-1:0] MidCnt  = SW'(MID_SAMPLE);
  localparam logic [SW-1:0] LastCnt = SW'(LAST_SAMPLE);
  localparam logic [BW-1:0] LastBit = BW'(DATA_BITS - 1);

  logic                 rx_s;
  logic [2:0]           state_q, state_d;
  logic [SW-1:0]        sample_q, sample_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_d;
  logic                 ready_d, frame_err_d, overrun_d, busy_d;
  logic                 complete;
`ifdef UART_RX_PARITY_EN
  logic                 par_q, par_d;
  logic                 parity_err_d;
`endif

  sync_2ff u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rx),
    .q     (rx_s)
  );

  always_comb begin
    state_d  = state_q;
    sample_d = sample_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    complete = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d    = par_q;
`endif
    if (rxclk_en) begin
      case (state_q)
        IDLE: begin
          if (!rx_s) begin
            state_d  = START;
            sample_d = '0;
          end
        end
        START: begin
          if (sample_q == MidCnt) begin
            // Mid start bit: still low means a real start, otherwise a glitch.
            sample_d = '0;
            bit_d    = '0;
            state_d  = rx_s ? IDLE : DATA;
          end else begin
            sample_d = sample_q + 1'b1;
          end
        end
        DATA: begin
          sample_d = sample_q + 1'b1;
          if (sample_q == LastCnt) begin
            shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
            bit_d   = bit_q + 1'b1;
            if (bit_q == LastBit) begin
              bit_d = '0;
`ifdef UART_RX_PARITY_EN
              state_d = PARITY;
`else
              state_d = STOP;
`endif
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          sample_d = sample_q + 1'b1;
          if (sample_q == LastCnt) begin
            par_d   = rx_s;
            state_d = STOP;
          end
        end
`endif
        STOP: begin
          sample_d = sample_q + 1'b1;
          if (sample_q == LastCnt) begin
            complete = 1'b1;
            // A low stop bit may be a break; wait for the line to go idle first.
            state_d  = rx_s ? IDLE : WAIT_HIGH;
          end
        end
        WAIT_HIGH: begin
          if (rx_s) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    data_d      = data;
    ready_d     = ready;
    frame_err_d = frame_err;
    overrun_d   = overrun;
`ifdef UART_RX_PARITY_EN
    parity_err_d = parity_err;
`endif
    if (complete) begin
      data_d      = shift_q;
      ready_d     = 1'b1;
      frame_err_d = ~rx_s;
      overrun_d   = overrun | (ready & ~rdy_clr);
`ifdef UART_RX_PARITY_EN
      parity_err_d = (^shift_q) ^ par_q;
`endif
    end else if (rdy_clr) begin
      ready_d   = 1'b0;
      overrun_d = 1'b0;
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      sample_q  <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      data      <= '0;
      ready     <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      busy      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q      <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      sample_q  <= sample_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      data      <= data_d;
      ready     <= ready_d;
      frame_err <= frame_err_d;
      overrun   <= overrun_d;
      busy      <= busy_d;
`ifdef UART_RX_PARITY_EN
      par_q      <= par_d;
      parity_err <= parity_err_d;
`endif
    end
  end

endmodule
